// File: rtl/uart_tx_fifo_rd.sv
// UART transmitter that pops bytes from an upstream FIFO (rd_en/empty/dout) and
// serialises them LSB first as start, data, optional parity, and 1 or 2 stop bits.
module uart_tx_fifo_rd #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 868,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_rd_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = $clog2(DATA_WIDTH + 1);

    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_PRE  = CW'(CLKS_PER_BIT - 2);
    localparam logic [BW-1:0] DATA_LAST = BW'(DATA_WIDTH - 1);
    localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_LOAD,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                state;
    logic [CW-1:0]         baud_cnt;
    logic [BW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift;
    logic [DATA_WIDTH-1:0] shift_nxt;
    logic                  parity;
    logic                  baud_end;

    assign baud_end  = (baud_cnt == BAUD_LAST);
    assign shift_nxt = shift >> 1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= S_IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift      <= '0;
            parity     <= 1'b0;
            fifo_rd_en <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            tx_done    <= 1'b0;
        end else begin
            fifo_rd_en <= 1'b0;
            tx_done    <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (!fifo_empty) begin
                        state      <= S_FETCH;
                        fifo_rd_en <= 1'b1;
                        busy       <= 1'b1;
                    end
                end
                // FIFO presents the popped word during the cycle after rd_en
                S_FETCH: state <= S_LOAD;
                S_LOAD: begin
                    shift    <= fifo_dout;
                    parity   <= (^fifo_dout) ^ (PARITY_ODD != 0);
                    baud_cnt <= '0;
                    bit_cnt  <= '0;
                    tx       <= 1'b0;
                    state    <= S_START;
                end
                S_START: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        tx       <= shift[0];
                        state    <= S_DATA;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        shift    <= shift_nxt;
                        if (bit_cnt == DATA_LAST) begin
                            bit_cnt <= '0;
                            if (PARITY_EN != 0) begin
                                tx    <= parity;
                                state <= S_PARITY;
                            end else begin
                                tx    <= 1'b1;
                                state <= S_STOP;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                            tx      <= shift_nxt[0];
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_PARITY: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        tx       <= 1'b1;
                        state    <= S_STOP;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (baud_end) begin
                        baud_cnt <= '0;
                        if (bit_cnt == STOP_LAST) begin
                            bit_cnt <= '0;
                            busy    <= 1'b0;
                            state   <= S_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                        // registered pulse lands on the final cycle of the last stop bit
                        if (baud_cnt == BAUD_PRE && bit_cnt == STOP_LAST)
                            tx_done <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo_rd.sv
// Bench for uart_tx_fifo_rd: four instances (8N1, even parity, odd parity, 2 stop bits)
// fed by FIFO models, with a byte scoreboard checked cycle by cycle against tx.
module tb_uart_tx_fifo_rd;
    localparam int CPB = 4;
    localparam int ND  = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [ND-1:0] empty_v = '1;
    logic [ND-1:0] rd_v, tx_v, busy_v, done_v;
    logic [7:0]    dout_v [ND];
    logic [7:0]    fq [ND][$];
    logic [7:0]    sb [ND][$];
    int            rd_cnt [ND];
    logic [ND-1:0] prev_rd = '0;
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    uart_tx_fifo_rd #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .rst(rst), .fifo_empty(empty_v[0]), .fifo_dout(dout_v[0]),
        .fifo_rd_en(rd_v[0]), .tx(tx_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]));
    uart_tx_fifo_rd #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(0), .STOP_BITS(1)) u_even (
        .clk(clk), .rst(rst), .fifo_empty(empty_v[1]), .fifo_dout(dout_v[1]),
        .fifo_rd_en(rd_v[1]), .tx(tx_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]));
    uart_tx_fifo_rd #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(1), .PARITY_ODD(1), .STOP_BITS(1)) u_odd (
        .clk(clk), .rst(rst), .fifo_empty(empty_v[2]), .fifo_dout(dout_v[2]),
        .fifo_rd_en(rd_v[2]), .tx(tx_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]));
    uart_tx_fifo_rd #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB), .PARITY_EN(0), .PARITY_ODD(0), .STOP_BITS(2)) u_2stop (
        .clk(clk), .rst(rst), .fifo_empty(empty_v[3]), .fifo_dout(dout_v[3]),
        .fifo_rd_en(rd_v[3]), .tx(tx_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]));

    function automatic int pe_of(input int d);   return (d == 1 || d == 2) ? 1 : 0; endfunction
    function automatic logic odd_of(input int d); return (d == 2) ? 1'b1 : 1'b0;     endfunction
    function automatic int sb_of(input int d);   return (d == 3) ? 2 : 1;            endfunction

    // FIFO model: registered empty flag, data valid the cycle after a pop
    always @(posedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (rd_v[d] === 1'b1 && fq[d].size() != 0) dout_v[d] <= fq[d].pop_front();
            empty_v[d] <= (fq[d].size() == 0);
        end
    end

    // pop handshake rules, checked on every pulse
    always @(negedge clk) begin
        for (int d = 0; d < ND; d++) begin
            if (rd_v[d] === 1'b1) begin
                rd_cnt[d]++;
                checks++;
                if (empty_v[d] !== 1'b0 || prev_rd[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL rd_en_rule[%0d]: empty=%b prev_rd_en=%b, want 0 and 0", d, empty_v[d], prev_rd[d]);
                end
            end
            prev_rd[d] = rd_v[d];
        end
    end

    task automatic push(input int d, input logic [7:0] b);
        fq[d].push_back(b);
        sb[d].push_back(b);
    endtask

    // counts tx-high cycles from the current negedge up to the start bit
    task automatic wait_start(input int d, input int exp_lat, input string name);
        int n;
        n = 0;
        while (tx_v[d] === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
        checks++;
        if (n != exp_lat || tx_v[d] !== 1'b0) begin
            errors++;
            $display("FAIL %s start_latency: got %0d cycles (tx=%b), want %0d then tx=0", name, n, tx_v[d], exp_lat);
        end
    endtask

    // called on the first negedge of the start bit; ends on the first idle cycle
    task automatic rx_frame(input int d, input string name);
        logic [7:0]  b;
        logic [15:0] bits;
        logic        exp_done;
        int          nb;
        checks++;
        if (sb[d].size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard: got empty queue, want a pending byte", name);
            return;
        end
        b    = sb[d].pop_front();
        bits = '1;
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[1+i] = b[i];
        if (pe_of(d) != 0) bits[9] = (^b) ^ odd_of(d);
        nb = 1 + 8 + pe_of(d) + sb_of(d);
        for (int i = 0; i < nb; i++) begin
            for (int c = 0; c < CPB; c++) begin
                exp_done = (i == nb - 1 && c == CPB - 1);
                checks++;
                if (tx_v[d] !== bits[i] || busy_v[d] !== 1'b1 || done_v[d] !== exp_done) begin
                    errors++;
                    $display("FAIL %s byte %h bit %0d clk %0d: tx/busy/done got %b%b%b, want %b1%b",
                             name, b, i, c, tx_v[d], busy_v[d], done_v[d], bits[i], exp_done);
                end
                @(negedge clk);
            end
        end
        checks++;
        if (tx_v[d] !== 1'b1 || busy_v[d] !== 1'b0 || done_v[d] !== 1'b0) begin
            errors++;
            $display("FAIL %s frame_end: tx/busy/done got %b%b%b, want 100", name, tx_v[d], busy_v[d], done_v[d]);
        end
    endtask

    task automatic test_reset();
        push(0, 8'h55);
        repeat (5) begin
            @(negedge clk);
            for (int d = 0; d < ND; d++) begin
                checks++;
                if (tx_v[d] !== 1'b1 || busy_v[d] !== 1'b0 || done_v[d] !== 1'b0 || rd_v[d] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_state[%0d]: tx/busy/done/rd got %b%b%b%b, want 1000",
                             d, tx_v[d], busy_v[d], done_v[d], rd_v[d]);
                end
            end
        end
    endtask

    task automatic test_basic();
        int base;
        base = rd_cnt[0];
        rst  = 1'b1;
        // byte was already in the FIFO, so empty is low on the first IDLE cycle
        wait_start(0, 3, "basic");
        rx_frame(0, "basic");
        checks++;
        if (rd_cnt[0] - base != 1) begin
            errors++;
            $display("FAIL basic rd_en_pulses: got %0d, want 1", rd_cnt[0] - base);
        end
    endtask

    task automatic test_idle();
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            checks++;
            if (tx_v[0] !== 1'b1 || rd_v[0] !== 1'b0 || busy_v[0] !== 1'b0) begin
                errors++;
                $display("FAIL idle cycle %0d: tx/rd/busy got %b%b%b, want 100", i, tx_v[0], rd_v[0], busy_v[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int base;
        base = rd_cnt[0];
        push(0, 8'hA3);
        push(0, 8'h0F);
        // one extra cycle for the FIFO's registered empty flag
        wait_start(0, 4, "b2b_first");
        rx_frame(0, "b2b_first");
        wait_start(0, 3, "b2b_gap");
        rx_frame(0, "b2b_second");
        checks++;
        if (rd_cnt[0] - base != 2) begin
            errors++;
            $display("FAIL b2b rd_en_pulses: got %0d, want 2", rd_cnt[0] - base);
        end
    endtask

    task automatic test_parity();
        push(1, 8'h07);
        wait_start(1, 4, "parity_even");
        rx_frame(1, "parity_even");
        push(2, 8'h07);
        wait_start(2, 4, "parity_odd");
        rx_frame(2, "parity_odd");
    endtask

    task automatic test_stop2();
        push(3, 8'hFF);
        wait_start(3, 4, "stop2");
        rx_frame(3, "stop2");
    endtask

    task automatic test_reset_mid();
        int base;
        push(0, 8'h81);
        wait_start(0, 4, "abort");
        repeat (16) @(negedge clk);
        checks++;
        if (tx_v[0] !== 1'b0 || busy_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort data_bit3: tx/busy got %b%b, want 01", tx_v[0], busy_v[0]);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (tx_v[0] !== 1'b1 || busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
            errors++;
            $display("FAIL abort reset_edge: tx/busy/done got %b%b%b, want 100", tx_v[0], busy_v[0], done_v[0]);
        end
        void'(sb[0].pop_front());
        @(negedge clk);
        rst  = 1'b1;
        base = rd_cnt[0];
        repeat (20) @(negedge clk);
        checks++;
        if (rd_cnt[0] != base || tx_v[0] !== 1'b1) begin
            errors++;
            $display("FAIL abort post_reset_idle: rd_en pulses %0d tx=%b, want 0 pulses tx=1", rd_cnt[0] - base, tx_v[0]);
        end
        push(0, 8'h3C);
        wait_start(0, 4, "after_abort");
        rx_frame(0, "after_abort");
    endtask

    initial begin
        for (int d = 0; d < ND; d++) dout_v[d] = 8'h00;
        test_reset();
        test_basic();
        test_idle();
        test_back_to_back();
        test_parity();
        test_stop2();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
